// File: rtl/unified_mem_ctrl.sv
// Shared instruction/data memory controller: one access at a time, data port wins ties,
// and a misaligned access that spills into the next word takes one extra cycle.
module unified_mem_ctrl #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        busy
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WORD0, WORD1, DONE} state_t;

  state_t            state_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [IDX_W-1:0]  idx_inc;
  logic [1:0]        off_reg;
  logic [1:0]        size_reg;
  logic              uns_reg;
  logic              we_reg;
  logic              src_d_reg;
  logic              cross_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       lo_reg;
  logic [31:0]       rd_q;
  logic [31:0]       if_rdata_reg;
  logic [31:0]       d_rdata_reg;
  logic              if_valid_reg;
  logic              d_valid_reg;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              acc_d;
  logic              acc_i;
  logic [31:0]       sel_addr;
  logic [1:0]        sel_size;
  logic              sel_uns;
  logic [2:0]        sel_nbytes;
  logic              sel_cross;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [7:0]        be64;
  logic [63:0]       wd64;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;
  logic [63:0]       rd64;
  logic [31:0]       shifted;
  logic [31:0]       load_val;
  logic              finish;
  logic              unused_if_bit0;

  assign unused_if_bit0 = if_addr[0];

  assign acc_d = (state_reg == IDLE) && d_req && !reset;
  assign acc_i = (state_reg == IDLE) && !d_req && if_req && !reset;

  always_comb begin
    sel_addr = d_req ? d_addr : {if_addr[31:1], 1'b0};
    sel_size = 2'd2;
    sel_uns  = 1'b0;
    if (d_req) begin
      case (d_funct3)
        3'b000:  sel_size = 2'd0;
        3'b001:  sel_size = 2'd1;
        3'b100:  begin sel_size = 2'd0; sel_uns = 1'b1; end
        3'b101:  begin sel_size = 2'd1; sel_uns = 1'b1; end
        default: sel_size = 2'd2;
      endcase
    end
    case (sel_size)
      2'd0:    sel_nbytes = 3'd1;
      2'd1:    sel_nbytes = 3'd2;
      default: sel_nbytes = 3'd4;
    endcase
    sel_cross = ({1'b0, sel_addr[1:0]} + sel_nbytes) > 3'd4;
  end

  assign sel_idx = IDX_W'({2'b00, sel_addr[31:2]} % 32'(DEPTH_WORDS));
  assign idx_inc = (idx_reg == IDX_W'(DEPTH_WORDS - 1)) ? '0 : idx_reg + IDX_W'(1);

  // The word for WORD0 is read while granting, the spill word while in WORD0,
  // so each state sees its word already registered out of the RAM.
  assign rd_idx = (state_reg == IDLE) ? sel_idx : idx_inc;

  always_comb begin
    case (size_reg)
      2'd0:    be64 = 8'h01 << off_reg;
      2'd1:    be64 = 8'h03 << off_reg;
      default: be64 = 8'h0F << off_reg;
    endcase
    wd64 = {32'b0, wdata_reg} << {off_reg, 3'b000};
  end

  assign wr_en   = !reset && we_reg && src_d_reg && (state_reg == WORD0 || state_reg == WORD1);
  assign wr_idx  = (state_reg == WORD1) ? idx_inc : idx_reg;
  assign wr_data = (state_reg == WORD1) ? wd64[63:32] : wd64[31:0];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wr_be[gi] = wr_en && ((state_reg == WORD1) ? be64[gi+4] : be64[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
    rd_q <= mem[rd_idx];
  end

  always_comb begin
    rd64    = (state_reg == WORD1) ? {rd_q, lo_reg} : {rd_q, rd_q};
    shifted = 32'(rd64 >> {off_reg, 3'b000});
    case (size_reg)
      2'd0:    load_val = uns_reg ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    load_val = uns_reg ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  assign finish = ((state_reg == WORD0) && !cross_reg) || (state_reg == WORD1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      if_valid_reg <= 1'b0;
      d_valid_reg  <= 1'b0;
      if_rdata_reg <= 32'h0;
      d_rdata_reg  <= 32'h0;
    end else begin
      if_valid_reg <= 1'b0;
      d_valid_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (acc_d || acc_i) begin
            idx_reg   <= sel_idx;
            off_reg   <= sel_addr[1:0];
            size_reg  <= sel_size;
            uns_reg   <= sel_uns;
            cross_reg <= sel_cross;
            we_reg    <= acc_d && d_we;
            src_d_reg <= acc_d;
            wdata_reg <= d_wdata;
            state_reg <= WORD0;
          end
        end
        WORD0: begin
          lo_reg    <= rd_q;
          state_reg <= cross_reg ? WORD1 : DONE;
        end
        WORD1:   state_reg <= DONE;
        default: state_reg <= IDLE;
      endcase
      // Result is registered on entry to DONE so it is visible alongside the valid pulse.
      if (finish) begin
        if (src_d_reg) begin
          d_valid_reg <= 1'b1;
          if (!we_reg) d_rdata_reg <= load_val;
        end else begin
          if_valid_reg <= 1'b1;
          if_rdata_reg <= load_val;
        end
      end
    end
  end

  assign if_gnt   = acc_i;
  assign d_gnt    = acc_d;
  assign if_valid = if_valid_reg;
  assign d_valid  = d_valid_reg;
  assign if_rdata = if_rdata_reg;
  assign d_rdata  = d_rdata_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Scoreboard bench for unified_mem_ctrl: a byte-array model predicts every response at grant
// time, and an independent monitor checks each valid pulse against it.
module tb_unified_mem_ctrl;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_gnt, if_valid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_funct3 = 3'b010;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_gnt, d_valid;
  logic [31:0] d_rdata;
  logic        busy;

  always #5 clk = ~clk;

  unified_mem_ctrl #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .busy(busy)
  );

  typedef struct {
    bit          src_d;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [7:0]  mdl [DEPTH*4];
  logic [31:0] last_d = 32'h0;
  logic [31:0] last_if = 32'h0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_dv_cyc = -1;
  int          last_iv_cyc = -1;
  int          gd, gf;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  // Byte k of an access starting at byte address a, wrapped over the word array.
  function automatic int bidx(input logic [31:0] a, input int k);
    longint w;
    int     pos;
    pos = int'(a[1:0]) + k;
    w   = (longint'(a[31:2]) + longint'(pos / 4)) % DEPTH;
    return int'(w) * 4 + pos % 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input int n, input bit sgn);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = mdl[bidx(a, k)];
    if (sgn && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (sgn && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic model_data(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int c);
    int n, lat;
    n   = nbytes(f3);
    lat = (int'(a[1:0]) + n > 4) ? 3 : 2;
    if (we) begin
      for (int k = 0; k < n; k++) mdl[bidx(a, k)] = wd[8*k +: 8];
    end else begin
      last_d = model_read(a, n, (f3 == 3'b000) || (f3 == 3'b001));
    end
    sb.push_back('{src_d: 1'b1, data: last_d, due: c + lat});
  endtask

  task automatic model_fetch(input logic [31:0] a, input int c);
    logic [31:0] fa;
    int lat;
    fa  = {a[31:1], 1'b0};
    lat = (int'(fa[1:0]) + 4 > 4) ? 3 : 2;
    last_if = model_read(fa, 4, 1'b0);
    sb.push_back('{src_d: 1'b0, data: last_if, due: c + lat});
  endtask

  task automatic do_data(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int gcyc);
    bit got;
    got  = 1'b0;
    gcyc = -1;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
    for (int t = 0; t < 64 && !got; t++) begin
      @(negedge clk);
      if (d_gnt) begin
        got  = 1'b1;
        gcyc = cyc;
        model_data(we, f3, a, wd, cyc);
      end
      @(posedge clk); #1;
    end
    d_req = 1'b0;
    if (!got) begin
      total++; bad++;
      $display("FAIL d_gnt_timeout: got none expected d_gnt for addr %h", a);
    end
  endtask

  task automatic do_fetch(input logic [31:0] a, output int gcyc);
    bit got;
    got  = 1'b0;
    gcyc = -1;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = a;
    for (int t = 0; t < 64 && !got; t++) begin
      @(negedge clk);
      if (if_gnt) begin
        got  = 1'b1;
        gcyc = cyc;
        model_fetch(a, cyc);
      end
      @(posedge clk); #1;
    end
    if_req = 1'b0;
    if (!got) begin
      total++; bad++;
      $display("FAIL if_gnt_timeout: got none expected if_gnt for addr %h", a);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL wait_idle: got %0d outstanding expected 0", sb.size());
    end
  endtask

  // Monitor: pops one expectation per valid pulse.
  always @(negedge clk) begin
    if (d_valid || if_valid) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_valid: got d_valid=%0b if_valid=%0b expected none", d_valid, if_valid);
      end else begin
        mon_e = sb.pop_front();
        chk("valid_src", {31'b0, d_valid}, {31'b0, mon_e.src_d});
        chk("one_valid", {31'b0, d_valid & if_valid}, 32'h0);
        chk("latency", 32'(cyc), 32'(mon_e.due));
        if (mon_e.src_d) chk("d_rdata", d_rdata, mon_e.data);
        else             chk("if_rdata", if_rdata, mon_e.data);
        if (d_valid) last_dv_cyc = cyc;
        else         last_iv_cyc = cyc;
        $display("txn %s cyc=%0d rdata=%h exp=%h", mon_e.src_d ? "D " : "IF", cyc,
                 mon_e.src_d ? d_rdata : if_rdata, mon_e.data);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [31:0] a;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_valid", {30'b0, d_valid, if_valid}, 32'h0);
    chk("rst_gnt", {30'b0, d_gnt, if_gnt}, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int w = 0; w < DEPTH; w++) do_data(1'b1, 3'b010, 32'(w * 4), $urandom(), gd);
    wait_idle();

    do_data(1'b1, 3'b010, 32'h10, 32'h11223344, gd); wait_idle();
    chk("sw_lat", 32'(last_dv_cyc - gd), 32'd2);
    chk("sw_keeps_rdata", d_rdata, 32'h0);
    do_data(1'b0, 3'b010, 32'h10, 32'h0, gd); wait_idle();
    chk("lw_10", d_rdata, 32'h11223344);
    chk("lw_lat", 32'(last_dv_cyc - gd), 32'd2);

    do_data(1'b1, 3'b000, 32'h11, 32'h12345680, gd); wait_idle();
    do_data(1'b0, 3'b000, 32'h11, 32'h0, gd); wait_idle();
    chk("lb_11", d_rdata, 32'hFFFFFF80);
    do_data(1'b0, 3'b100, 32'h11, 32'h0, gd); wait_idle();
    chk("lbu_11", d_rdata, 32'h00000080);
    do_data(1'b0, 3'b010, 32'h10, 32'h0, gd); wait_idle();
    chk("lw_10_sb", d_rdata, 32'h11228044);

    do_data(1'b1, 3'b010, 32'h14, 32'hAABBCCDD, gd); wait_idle();
    do_fetch(32'h12, gf); wait_idle();
    chk("fetch_12", if_rdata, 32'hCCDD1122);
    chk("fetch_lat", 32'(last_iv_cyc - gf), 32'd3);
    do_fetch(32'h13, gf); wait_idle();
    chk("fetch_13", if_rdata, 32'hCCDD1122);

    fork
      do_data(1'b0, 3'b010, 32'h10, 32'h0, gd);
      do_fetch(32'h14, gf);
    join
    wait_idle();
    chk("tie_if_after_dvalid", 32'(gf), 32'(gd + 3));
    chk("tie_if_rdata", if_rdata, 32'hAABBCCDD);

    do_data(1'b1, 3'b010, 32'(DEPTH * 4 - 2), 32'hDEADBEEF, gd); wait_idle();
    do_data(1'b0, 3'b101, 32'(DEPTH * 4 - 2), 32'h0, gd); wait_idle();
    chk("wrap_lhu_last", d_rdata, 32'h0000BEEF);
    do_data(1'b0, 3'b100, 32'h0, 32'h0, gd); wait_idle();
    chk("wrap_lbu_0", d_rdata, 32'h000000AD);
    do_data(1'b0, 3'b100, 32'h1, 32'h0, gd); wait_idle();
    chk("wrap_lbu_1", d_rdata, 32'h000000DE);
    do_data(1'b0, 3'b010, 32'(DEPTH * 4 - 2), 32'h0, gd); wait_idle();
    chk("wrap_lw", d_rdata, 32'hDEADBEEF);
    chk("wrap_lat", 32'(last_dv_cyc - gd), 32'd3);

    do_data(1'b1, 3'b010, 32'h20, 32'h01020304, gd);
    do_data(1'b1, 3'b010, 32'h24, 32'h0A0B0C0D, gd);
    wait_idle();
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 32'h22; d_wdata = 32'h55667788;
    @(negedge clk);
    chk("rst_test_gnt", {31'b0, d_gnt}, 32'h1);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_test_busy_word1", {31'b0, busy}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    mdl[bidx(32'h22, 0)] = 8'h88;
    mdl[bidx(32'h22, 1)] = 8'h77;
    last_d  = 32'h0;
    last_if = 32'h0;
    @(negedge clk);
    chk("rst_test_idle", {31'b0, busy}, 32'h0);
    chk("rst_test_no_valid", {31'b0, d_valid}, 32'h0);
    chk("rst_test_d_rdata", d_rdata, 32'h0);
    @(negedge clk);
    chk("rst_test_no_valid2", {31'b0, d_valid}, 32'h0);
    do_data(1'b0, 3'b010, 32'h24, 32'h0, gd); wait_idle();
    chk("rst_test_word1_kept", d_rdata, 32'h0A0B0C0D);
    do_data(1'b0, 3'b010, 32'h20, 32'h0, gd); wait_idle();
    chk("rst_test_word0_low", d_rdata, 32'h77880304);

    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 3));
      a = $urandom();
      case (r)
        0: do_data(1'b0, 3'($urandom_range(0, 7)), a, 32'h0, gd);
        1: do_data(1'b1, 3'($urandom_range(0, 7)), a, $urandom(), gd);
        2: do_fetch(a, gf);
        default: begin
          fork
            do_data($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), a, $urandom(), gd);
            do_fetch($urandom(), gf);
          join
        end
      endcase
    end
    wait_idle();
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unified_mem_ctrl.md
UNIFIED_MEM_CTRL -- requirements
Module: unified_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit words in the internal little-endian storage array.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port if_req, input, 1 bit: instruction-fetch request.
REQ-005 The block SHALL have port if_addr, input, 32 bits: fetch byte address; bit 0 is ignored.
REQ-006 The block SHALL have port if_gnt, output, 1 bit: one-cycle pulse when the fetch request is accepted.
REQ-007 The block SHALL have port if_valid, output, 1 bit: one-cycle pulse when if_rdata holds the fetched 32-bit instruction.
REQ-008 The block SHALL have port if_rdata, output, 32 bits: fetched instruction.
REQ-009 The block SHALL have port d_req, input, 1 bit: data request.
REQ-010 The block SHALL have port d_we, input, 1 bit: 1 for a store, 0 for a load.
REQ-011 The block SHALL have port d_funct3, input, 3 bits: access size and sign; 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned; other codes are treated as 010.
REQ-012 The block SHALL have port d_addr, input, 32 bits: data byte address.
REQ-013 The block SHALL have port d_wdata, input, 32 bits: store data, taken from the low 8, 16 or 32 bits.
REQ-014 The block SHALL have port d_gnt, output, 1 bit: one-cycle pulse when the data request is accepted.
REQ-015 The block SHALL have port d_valid, output, 1 bit: one-cycle pulse when a load or store has completed.
REQ-016 The block SHALL have port d_rdata, output, 32 bits: load result, sign- or zero-extended.
REQ-017 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, WORD0, WORD1 and DONE.
REQ-019 In IDLE, an asserted d_req SHALL be accepted in preference to if_req; a simultaneous if_req SHALL stay pending and be accepted no earlier than the next return to IDLE.
REQ-020 On acceptance, the block SHALL pulse the matching gnt for that cycle, register the address, size, wdata, we and source, and enter WORD0.
REQ-021 Requests present while the FSM is not in IDLE SHALL NOT be accepted and SHALL NOT be lost if held; requesters hold req, addr and data until gnt.
REQ-022 Storage SHALL be indexed by word address addr[31:2] modulo DEPTH_WORDS (wrap-around, no error).
REQ-023 Access width SHALL be 4 bytes for a fetch and 1, 2 or 4 bytes for data.
REQ-024 An access crosses a word boundary when the byte offset (addr[1:0]) plus the width exceeds 4.
REQ-025 WORD0 SHALL access the word at index i; on a crossing the FSM SHALL go to WORD1 and access word (i+1) mod DEPTH_WORDS, otherwise it SHALL go directly to DONE.
REQ-026 Stores SHALL write only the byte lanes the access covers and leave all other bytes unchanged; a crossing store SHALL write its low bytes in WORD0 and its high bytes in WORD1.
REQ-027 Loads and fetches SHALL assemble the addressed bytes little-endian; byte and half loads SHALL be sign-extended for funct3 000/001 and zero-extended for 100/101.
REQ-028 DONE SHALL pulse if_valid or d_valid (by source) for exactly one cycle and update the matching rdata register, then return to IDLE.
REQ-029 Latency from gnt to valid SHALL be 2 cycles for a non-crossing access and 3 cycles for a crossing access.
REQ-030 A new request SHALL be grantable in the cycle after DONE.
REQ-031 if_rdata and d_rdata SHALL hold their values until the next valid pulse for the same source.
REQ-032 A store SHALL leave d_rdata unchanged and still pulse d_valid.

Reset
REQ-033 When reset is sampled high, the FSM SHALL enter IDLE.
REQ-034 When reset is sampled high, if_gnt, d_gnt, if_valid, d_valid and busy SHALL be 0.
REQ-035 When reset is sampled high, if_rdata and d_rdata SHALL be 0x00000000.
REQ-036 An access in progress when reset is sampled high SHALL be abandoned with no valid pulse; any WORD1 write not yet performed SHALL NOT occur.
REQ-037 Storage contents SHALL NOT be cleared by reset.

Verification
REQ-038 Bench SHALL cover: SW 0x11223344 at 0x10, then LW at 0x10 -> d_rdata = 0x11223344, valid 2 cycles after each gnt.
REQ-039 Bench SHALL cover: SB 0x80 at 0x11, then LB at 0x11 -> 0xFFFFFF80; LBU at 0x11 -> 0x00000080; LW at 0x10 -> 0x11228044.
REQ-040 Bench SHALL cover: word 0x14 = 0xAABBCCDD, fetch at 0x12 -> 3-cycle latency, if_rdata = 0xCCDD1122.
REQ-041 Bench SHALL cover: if_req and d_req raised in the same IDLE cycle -> d_gnt first; if_gnt in the cycle after d_valid.
REQ-042 Bench SHALL cover: SW 0xDEADBEEF at (DEPTH_WORDS*4 - 2) -> bytes EF BE land in the last word and AD DE land at addresses 0x0 and 0x1.
REQ-043 Bench SHALL cover: reset asserted during WORD1 of a crossing store -> no d_valid, FSM in IDLE next cycle, and the second word unchanged.
